// File: rtl/bin2bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_pkg
//
// Shared definitions for the binary-to-BCD converter and the display blocks
// that consume its packed BCD result.
//
// Contents:
//   state_e     - converter FSM state encoding (IDLE / SHIFT / DONE)
//   MAX_DEC     - largest value an 8-digit decimal display can show
//   BCD_SAT     - packed BCD pattern shown when the input exceeds MAX_DEC
//   BCD_DIGITS  - number of packed BCD digits in the result word
//   dig_adjust  - double-dabble digit correction ("add 3 if >= 5")
// -----------------------------------------------------------------------------
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [31:0] MAX_DEC    = 32'd99_999_999;
  localparam logic [31:0] BCD_SAT    = 32'h9999_9999;
  localparam int          BCD_DIGITS = 8;

  // A digit of 5..9 would become >= 10 after the following left shift, so it
  // is pre-biased by 3 so the shift carries cleanly into the next digit.
  function automatic logic [3:0] dig_adjust(input logic [3:0] dig);
    return (dig >= 4'd5) ? (dig + 4'd3) : dig;
  endfunction

endpackage : bin2bcd_seq_pkg

// File: rtl/bin2bcd_seq_dig_adj.sv
// -----------------------------------------------------------------------------
// bcd_dig_adj
//
// Purely combinational per-digit corrector for one double-dabble step.
//
// Ports:
//   dig_i  in   4  BCD digit before correction
//   dig_o  out  4  dig_i + 3 when dig_i >= 5, otherwise dig_i
// -----------------------------------------------------------------------------
module bcd_dig_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  assign dig_o = dig_adjust(dig_i);

endmodule : bcd_dig_adj

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential (one bit per clock) double-dabble binary-to-BCD converter that
// feeds a 2x4-digit seven-segment display. A conversion takes NBIN shift
// cycles followed by a single DONE cycle. Values above 99,999,999 cannot be
// shown on eight digits, so they saturate to all nines and raise ovf.
//
// Parameters:
//   NBIN   binary input width, 4..27
//
// Ports:
//   clk    in   1     clock, all state changes on the rising edge
//   reset  in   1     synchronous active-high reset
//   start  in   1     conversion request, only looked at in IDLE
//   bin    in   NBIN  unsigned value, captured when start is accepted
//   bcd    out  32    registered packed BCD result, digit 7 in [31:28]
//   busy   out  1     high whenever the FSM is not in IDLE
//   done   out  1     one-cycle pulse marking fresh bcd/ovf values
//   ovf    out  1     last converted value was above 99,999,999
//
// bcd/ovf only change on the edge that completes a conversion (or on reset),
// so the display keeps the previous result steady while a new one is built.
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int NBIN = 27
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [NBIN-1:0] bin,
  output logic [31:0]     bcd,
  output logic            busy,
  output logic            done,
  output logic            ovf
);

  localparam int CNT_W = $clog2(NBIN);

  // Reject out-of-range widths at elaboration rather than build a broken core.
  if ((NBIN < 4) || (NBIN > 27)) begin : g_bad_nbin
    $error("bin2bcd_seq: NBIN must be in 4..27");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;         // iterations remaining after this one
  logic [NBIN-1:0]   sh_q, sh_d;           // binary shift register, MSB first
  logic [31:0]       acc_q, acc_d;         // BCD accumulator under construction
  logic              ovf_pend_q, ovf_pend_d;
  logic [31:0]       bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Overflow detection at capture time
  // ---------------------------------------------------------------------------
  // Below 27 bits the largest input (2^26-1) already fits in eight digits, so
  // the comparator is only built where overflow is actually possible.
  logic ovf_in;

  if (NBIN >= 27) begin : g_ovf_cmp
    assign ovf_in = ({{(32-NBIN){1'b0}}, bin} > MAX_DEC);
  end else begin : g_ovf_none
    assign ovf_in = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // One double-dabble iteration: correct every digit, then shift left by one
  // ---------------------------------------------------------------------------
  logic [31:0]     acc_adj;
  logic [31:0]     acc_shift;
  logic [NBIN-1:0] sh_shift;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dig
    bcd_dig_adj u_dig_adj (
      .dig_i (acc_q[4*g +: 4]),
      .dig_o (acc_adj[4*g +: 4])
    );
  end

  assign acc_shift = {acc_adj[30:0], sh_q[NBIN-1]};
  assign sh_shift  = {sh_q[NBIN-2:0], 1'b0};

  // The bit shifted out of digit 7 only matters for values above 99,999,999,
  // and those results are replaced by the saturation pattern anyway.
  logic unused_acc_msb;
  assign unused_acc_msb = acc_adj[31];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets its hold value before the case statement; any
  // path that left one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_d       = bin;
          acc_d      = '0;
          cnt_d      = CNT_W'(NBIN - 1);
          ovf_pend_d = ovf_in;
          state_d    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        acc_d = acc_shift;
        sh_d  = sh_shift;
        if (cnt_q == '0) begin
          // Final iteration: publish the post-shift accumulator directly so
          // the result is ready on the same edge.
          bcd_d   = ovf_pend_q ? BCD_SAT : acc_shift;
          ovf_d   = ovf_pend_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        // start is deliberately ignored here; a new request is only taken
        // once back in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      acc_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // busy and done decode the registered state only, so both are glitch-free.
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//
// Self-checking bench for bin2bcd_seq (NBIN = 27). Inputs are driven and
// outputs sampled on the falling clock edge; expected values come from a
// hand-written vector table and an arithmetic (divide/modulo) decimal model.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int NBIN = 27;

  logic            clk;
  logic            reset;
  logic            start;
  logic [NBIN-1:0] bin;
  logic [31:0]     bcd;
  logic            busy;
  logic            done;
  logic            ovf;

  bin2bcd_seq #(.NBIN(NBIN)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Result the display should keep showing while a conversion runs.
  logic [31:0] prev_bcd;
  logic        prev_ovf;

  typedef struct {
    string           name;
    logic [NBIN-1:0] bin;
    logic [31:0]     bcd;
    logic            ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Independent decimal model: saturate above 99,999,999, else digit by digit.
  function automatic logic [31:0] ref_bcd(input logic [NBIN-1:0] b);
    int unsigned v;
    logic [31:0] r;
    v = 32'(b);
    r = '0;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Launch one conversion and check latency, result, busy length, the single
  // done pulse and that bcd/ovf held their previous values during SHIFT.
  task automatic run_conv(input string name, input logic [NBIN-1:0] b,
                          input logic [31:0] exp_bcd, input logic exp_ovf,
                          input bit launch_now);
    int n;
    int busy_n;
    bit stable;
    if (!launch_now) @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(negedge clk);
    start = 1'b0;
    bin   = ~b;  // must not disturb the captured value
    n      = 0;
    busy_n = 0;
    stable = 1'b1;
    while (!done && n < 60) begin
      if (busy) busy_n++;
      if (bcd !== prev_bcd || ovf !== prev_ovf) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    if (busy) busy_n++;
    check({name, " latency"}, n, NBIN);
    check({name, " bcd"}, bcd, exp_bcd);
    check({name, " ovf"}, 32'(ovf), 32'(exp_ovf));
    check({name, " stable"}, 32'(stable), 32'd1);
    @(negedge clk);
    check({name, " done_pulse"}, 32'(done), 32'd0);
    check({name, " busy_cycles"}, busy_n + (busy ? 1 : 0), NBIN + 1);
    prev_bcd = exp_bcd;
    prev_ovf = exp_ovf;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    int  dones;
    bit  stable;
    logic [NBIN-1:0] rb;

    vecs[0]  = '{"zero",      27'd0,           32'h0000_0000, 1'b0};
    vecs[1]  = '{"one",       27'd1,           32'h0000_0001, 1'b0};
    vecs[2]  = '{"nine",      27'd9,           32'h0000_0009, 1'b0};
    vecs[3]  = '{"ten",       27'd10,          32'h0000_0010, 1'b0};
    vecs[4]  = '{"ninetynine",27'd99,          32'h0000_0099, 1'b0};
    vecs[5]  = '{"k65535",    27'd65_535,      32'h0006_5535, 1'b0};
    vecs[6]  = '{"seq",       27'd12_345_678,  32'h1234_5678, 1'b0};
    vecs[7]  = '{"ten_mil",   27'd10_000_000,  32'h1000_0000, 1'b0};
    vecs[8]  = '{"max_m1",    27'd99_999_998,  32'h9999_9998, 1'b0};
    vecs[9]  = '{"max",       27'd99_999_999,  32'h9999_9999, 1'b0};
    vecs[10] = '{"max_p1",    27'd100_000_000, 32'h9999_9999, 1'b1};
    vecs[11] = '{"all_ones",  27'd134_217_727, 32'h9999_9999, 1'b1};
    vecs[12] = '{"after_ovf", 27'd5_555,       32'h0000_5555, 1'b0};
    vecs[13] = '{"mixed",     27'd80_706_050,  32'h8070_6050, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("rst bcd",  bcd, 32'h0);
    check("rst ovf",  32'(ovf), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    reset    = 1'b0;
    prev_bcd = '0;
    prev_ovf = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 14; i++)
      run_conv(vecs[i].name, vecs[i].bin, vecs[i].bcd, vecs[i].ovf, 1'b0);

    // start pulses while busy (mid-SHIFT and in DONE) must be ignored.
    @(negedge clk);
    start = 1'b1;
    bin   = 27'd42;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    dones = 0;
    while (!done && n < 60) begin
      if (n == 5) begin start = 1'b1; bin = 27'd7; end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    check("ign latency", n, NBIN);
    check("ign bcd", bcd, 32'h0000_0042);
    start = 1'b1;  // arrives during DONE
    bin   = 27'd7;
    @(negedge clk);
    start = 1'b0;
    check("ign done_once", 32'(done), 32'd0);
    check("ign no_restart", 32'(busy), 32'd0);
    check("ign bcd_held", bcd, 32'h0000_0042);
    prev_bcd = 32'h0000_0042;
    prev_ovf = 1'b0;
    // Start in the IDLE cycle right after done is accepted.
    run_conv("b2b_seven", 27'd7, 32'h0000_0007, 1'b0, 1'b1);

    // Reset mid-conversion: no done, outputs cleared, bcd held at 0 before.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort pre_bcd", bcd, 32'h0);
    start = 1'b1;
    bin   = 27'd5_555;
    @(negedge clk);
    start  = 1'b0;
    stable = 1'b1;
    dones  = 0;
    for (int i = 0; i < 10; i++) begin
      if (bcd !== 32'h0) stable = 1'b0;
      if (done) dones++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort bcd",  bcd, 32'h0);
    check("abort ovf",  32'(ovf), 32'd0);
    check("abort held", 32'(stable), 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("abort no_done", dones, 0);
    prev_bcd = '0;
    prev_ovf = 1'b0;

    // Random conversions against the decimal model, biased near the limit.
    for (int i = 0; i < 1000; i++) begin
      if (i % 8 == 0) rb = 27'(99_999_990 + $urandom_range(0, 20));
      else            rb = 27'($urandom_range(0, (1 << 27) - 1));
      run_conv("rand", rb, ref_bcd(rb), (32'(rb) > 32'd99_999_999), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bin2bcd_seq
